// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Definitions shared by the PS/2 host transmit and receive sides:
//             controller state encoding, frame length and the parity helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Host transmit controller states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_sync
//  Purpose  : Two-flop synchronizer for one PS/2 line plus a registered
//             falling-edge flag, raised the cycle after the synchronized
//             level drops from 1 to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
  input  logic sysClk,
  input  logic iRst_n,
  input  logic iLine,
  output logic oLevel,
  output logic oFall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  // Next-state: shift the line through the synchronizer and compare levels
  always_comb begin
    meta_d = iLine;
    sync_d = meta_q;
    prev_d = sync_q;
    fall_d = prev_q & ~sync_q;
  end

  // Registers; an idle PS/2 bus is high, so reset to 1 to avoid a false edge
  always_ff @(posedge sysClk) begin
    if (!iRst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign oLevel = sync_q;
  assign oFall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device command transmitter. Inhibits the clock,
//             issues request-to-send, shifts out data/parity/stop on device
//             clock falling edges, checks the device ACK, and guards the whole
//             frame with a watchdog. Lines are open-drain from registers.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic       sysClk,
  input  logic       iRst_n,
  input  logic       iSend,
  input  logic [7:0] iData,
  inout  wire        ps2clk,
  inout  wire        ps2data,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W          = $clog2(FRAME_LEN + 1);

  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  // Edge count (0-based) at which the stop bit is presented; edge 0 is the
  // start edge seen in REQ.
  localparam logic [BIT_W-1:0] STOP_EDGE = BIT_W'(FRAME_LEN - 2);

  logic             clk_lvl, clk_fall;
  logic             data_lvl, data_fall_unused;

  logic [2:0]       state_q,   state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q,  wd_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0]       shreg_q,   shreg_d;   // {parity, data}, LSB goes out first
  logic             clk_oe_q,  clk_oe_d;  // 1 = pull ps2clk low
  logic             data_oe_q, data_oe_d; // 1 = pull ps2data low
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;

  ps2_line_sync u_clk_sync (
    .sysClk (sysClk),
    .iRst_n (iRst_n),
    .iLine  (ps2clk),
    .oLevel (clk_lvl),
    .oFall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .sysClk (sysClk),
    .iRst_n (iRst_n),
    .iLine  (ps2data),
    .oLevel (data_lvl),
    .oFall  (data_fall_unused)
  );

  // Open-drain drivers straight from flops so state decode cannot glitch them
  assign ps2clk  = clk_oe_q  ? 1'b0 : 1'bz;
  assign ps2data = data_oe_q ? 1'b0 : 1'bz;

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oErr  = err_q;

  // Frame sequencing, line-driver next values and watchdog
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q != ST_IDLE) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (iSend) begin
          shreg_d   = {odd_parity(iData), iData};
          bit_cnt_d = '0;
          wd_cnt_d  = '0;
          inh_cnt_d = '0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = (INH_LAST == '0);
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          // data joins the clock low only for the final inhibit cycle
          data_oe_d = (inh_cnt_d == INH_LAST);
        end
      end

      ST_REQ: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        if (clk_fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[8:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == STOP_EDGE) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b1, shreg_q[8:1]};
          end
        end
      end

      ST_ACK: begin
        data_oe_d = 1'b0;
        if (clk_fall) begin
          if (!data_lvl) begin
            state_d = ST_FIN;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_FIN: begin
        if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Watchdog overrides everything so oDone and oErr can never coincide
    if ((state_q != ST_IDLE) && (wd_cnt_q == WD_LAST)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge sysClk) begin
    if (!iRst_n) begin
      state_q   <= ST_IDLE;
      inh_cnt_q <= '0;
      wd_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a PS/2 device model
//             clocking at 12.5 kHz (80 sysClk cycles at 1 MHz).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int CLK_HZ  = 1000000;
  localparam int INH_US  = 100;
  localparam int TO_MS   = 15;
  localparam int INH_CYC = 100;    // 1 MHz / 1e6 * 100 us
  localparam int TO_CYC  = 15000;  // 1 MHz / 1e3 * 15 ms
  localparam int HALF    = 40;     // half period of 12.5 kHz device clock

  logic       sysClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iSend  = 1'b0;
  logic [7:0] iData  = 8'h00;
  wire        ps2clk;
  wire        ps2data;
  logic       oBusy, oDone, oErr;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2data);

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .INHIBIT_US  (INH_US),
    .TIMEOUT_MS  (TO_MS)
  ) dut (
    .sysClk  (sysClk),
    .iRst_n  (iRst_n),
    .iSend   (iSend),
    .iData   (iData),
    .ps2clk  (ps2clk),
    .ps2data (ps2data),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oErr    (oErr)
  );

  always #5 sysClk = ~sysClk;

  int checks   = 0;
  int failures = 0;

  // pulse and busy-handshake monitor
  int   done_total = 0;
  int   err_total  = 0;
  int   both_total = 0;
  int   busy_bad   = 0;
  logic prev_busy  = 1'b0;

  always @(negedge sysClk) begin
    if (oDone) done_total <= done_total + 1;
    if (oErr) err_total <= err_total + 1;
    if (oDone && oErr) both_total <= both_total + 1;
    if (iRst_n && prev_busy && !oBusy && !oDone && !oErr) busy_bad <= busy_bad + 1;
    prev_busy <= oBusy;
  end

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] exp_frame;  // {stop, parity, d7..d0, start}
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_send(input logic [7:0] d);
    @(negedge sysClk);
    iData = d;
    iSend = 1'b1;
    @(negedge sysClk);
    iSend = 1'b0;
  endtask

  // Host request plus device clocking; samples each bit late in the low phase
  task automatic run_frame(input logic [7:0] d, input bit ack, input int abort_edge,
                           input int poke_edge, output int clk_low, output int overlap,
                           output logic [10:0] bits, output int busy_low);
    int guard;
    bits     = '0;
    busy_low = 0;
    clk_low  = 0;
    overlap  = 0;
    guard    = 0;
    start_send(d);
    while (ps2clk == 1'b0 && guard < 1000) begin
      clk_low++;
      if (ps2data == 1'b0) overlap++;
      @(negedge sysClk);
      guard++;
    end
    bits[0] = ps2data;
    repeat (HALF) @(negedge sysClk);
    for (int e = 1; e <= 11; e++) begin
      dev_clk_low = 1'b1;
      repeat (HALF / 2) @(negedge sysClk);
      if (e == poke_edge) begin
        iData = 8'h3C;
        iSend = 1'b1;
        @(negedge sysClk);
        iSend = 1'b0;
      end else begin
        @(negedge sysClk);
      end
      repeat (HALF / 2 - 1) @(negedge sysClk);
      if (e <= 10) begin
        bits[e] = ps2data;
        if (!oBusy) busy_low++;
      end
      dev_clk_low = 1'b0;
      if (e == abort_edge) return;
      if (e == 10 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge sysClk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (oBusy && n < max_cyc) begin
      @(negedge sysClk);
      n++;
    end
    repeat (5) @(negedge sysClk);
  endtask

  initial begin
    int          cl, ov, bl, n, d0, e0, bb0;
    logic [10:0] bits;

    vecs[0] = '{8'hF4, 1'b1, 11'b1_0_1111_0100_0, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 11'b1_1_1111_1111_0, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 11'b1_1_0000_0000_0, 1, 0};
    vecs[3] = '{8'hA5, 1'b0, 11'b1_1_1010_0101_0, 0, 1};

    // reset state
    iRst_n = 1'b0;
    repeat (5) @(negedge sysClk);
    check("reset_busy", int'(oBusy), 0);
    check("reset_done", int'(oDone), 0);
    check("reset_err", int'(oErr), 0);
    check("reset_lines", int'({ps2clk, ps2data}), 3);
    iRst_n = 1'b1;
    repeat (5) @(negedge sysClk);

    // table-driven frames
    for (int i = 0; i < 4; i++) begin
      d0  = done_total;
      e0  = err_total;
      bb0 = busy_bad;
      run_frame(vecs[i].data, vecs[i].ack, 0, 0, cl, ov, bits, bl);
      wait_idle(500);
      check("inhibit_len", cl, INH_CYC);
      check("inhibit_data_overlap", ov, 1);
      check("frame_bits", int'(bits), int'(vecs[i].exp_frame));
      check("busy_in_frame", bl, 0);
      check("done_pulses", done_total - d0, vecs[i].exp_done);
      check("err_pulses", err_total - e0, vecs[i].exp_err);
      check("busy_drop_no_pulse", busy_bad - bb0, 0);
      check("lines_released", int'({ps2clk, ps2data}), 3);
      check("busy_after", int'(oBusy), 0);
    end

    // watchdog: device never clocks
    d0 = done_total;
    start_send(8'h5A);
    n = 0;
    while (!oErr && n < TO_CYC + 100) begin
      @(negedge sysClk);
      n++;
    end
    check("wd_cycles", n, TO_CYC);
    check("wd_data_released", int'(ps2data), 1);
    check("wd_clk_released", int'(ps2clk), 1);
    check("wd_busy", int'(oBusy), 0);
    check("wd_no_done", int'(oDone), 0);
    repeat (10) @(negedge sysClk);
    check("wd_done_total", done_total - d0, 0);

    // reset after the 4th data bit
    d0 = done_total;
    e0 = err_total;
    run_frame(8'hF4, 1'b1, 4, 0, cl, ov, bits, bl);
    check("abort_partial_bits", int'(bits[4:0]), 5'b01000);
    check("abort_data_driven", int'(ps2data), 0);
    iRst_n = 1'b0;
    @(negedge sysClk);
    check("abort_lines_released", int'({ps2clk, ps2data}), 3);
    check("abort_busy", int'(oBusy), 0);
    repeat (3) @(negedge sysClk);
    iRst_n = 1'b1;
    repeat (50) @(negedge sysClk);
    check("abort_no_done", done_total - d0, 0);
    check("abort_no_err", err_total - e0, 0);
    run_frame(8'hF4, 1'b1, 0, 0, cl, ov, bits, bl);
    wait_idle(500);
    check("after_abort_bits", int'(bits), int'(11'b1_0_1111_0100_0));
    check("after_abort_done", done_total - d0, 1);
    check("after_abort_err", err_total - e0, 0);

    // iSend pulsed during SHIFT is ignored
    d0 = done_total;
    e0 = err_total;
    run_frame(8'h81, 1'b1, 0, 5, cl, ov, bits, bl);
    wait_idle(500);
    repeat (300) @(negedge sysClk);
    check("poke_bits", int'(bits), int'(11'b1_1_1000_0001_0));
    check("poke_single_done", done_total - d0, 1);
    check("poke_no_err", err_total - e0, 0);
    check("poke_no_second_frame", int'(ps2clk), 1);
    check("poke_busy", int'(oBusy), 0);

    check("done_err_overlap", both_total, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
